// File: rtl/mixcolumns_seq_if.sv
// Handshake bundle for the sequential MixColumns stage: upstream state in,
// downstream result out, plus the busy status flag.
interface mixcolumns_seq_if #(parameter int NCOL = 4);
  logic                 in_valid;
  logic                 in_ready;
  logic [NCOL*32-1:0]   in_state;
  logic                 in_bypass;
  logic                 out_valid;
  logic                 out_ready;
  logic [NCOL*32-1:0]   out_state;
  logic                 busy;

  // Block side
  modport slave (
    input  in_valid, in_state, in_bypass, out_ready,
    output in_ready, out_valid, out_state, busy
  );

  // Driver / consumer side
  modport master (
    output in_valid, in_state, in_bypass, out_ready,
    input  in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/mixcolumns_seq.sv
// Sequential AES MixColumns: one combinational column mixer is time-shared
// over the four columns of the buffered state, one column per cycle.
// Bypass (final round) skips the mixing and returns the state unchanged.

// One AES column through MixColumns, GF(2^8) mod 0x11B. Row r output is
// 2*b[r] ^ 3*b[r+1] ^ b[r+2] ^ b[r+3] (indices mod 4).
module mixcolumns_col (
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [3:0][7:0] w_b;
  logic [3:0][7:0] w_c;

  assign w_b   = i_col;
  assign o_col = w_c;

  for (genvar r = 0; r < 4; r++) begin : g_row
    assign w_c[r] = xt(w_b[r]) ^ xt(w_b[(r+1)%4]) ^ w_b[(r+1)%4]
                  ^ w_b[(r+2)%4] ^ w_b[(r+3)%4];
  end
endmodule

module mixcolumns_seq #(
  parameter int NCOL = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mixcolumns_seq_if.slave       bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [1:0]            r_cnt;
  logic [NCOL-1:0][31:0] r_buf;
  logic [31:0]           w_col_in;
  logic [31:0]           w_col_out;

  // Column selected by the counter feeds the single shared mixer.
  assign w_col_in = r_buf[r_cnt];

  mixcolumns_col u_mix (
    .i_col (w_col_in),
    .o_col (w_col_out)
  );

  // Result is the buffer itself; only meaningful while out_valid is high.
  assign bus.out_state = r_buf;

  // Next-state and handshake outputs. Bypass is decided at the accept edge,
  // so it never needs to be stored.
  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_next = bus.in_bypass ? S_DONE : S_RUN;
      end
      S_RUN: begin
        bus.busy = 1'b1;
        if (r_cnt == 2'd3) w_next = S_DONE;
      end
      S_DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register, column counter and state buffer; reset wins over all.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_buf   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && bus.in_valid) begin
        r_buf <= bus.in_state;
        r_cnt <= 2'd0;
      end else if (r_state == S_RUN) begin
        r_buf[r_cnt] <= w_col_out;
        r_cnt        <= r_cnt + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_mixcolumns_seq.sv
// Bench for mixcolumns_seq: transaction-level reference model with a
// per-cycle compare process, plus directed vectors with literal results.
module tb_mixcolumns_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mixcolumns_seq_if #(.NCOL(4)) bus ();
  mixcolumns_seq #(.NCOL(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // GF(2^8) multiply by shift-and-add, AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // Matrix-vector product with the circulant {2,3,1,1} on every column.
  function automatic logic [127:0] ref_state(input logic [127:0] s);
    logic [7:0] coef [4];
    logic [7:0] b [4];
    logic [7:0] acc;
    logic [127:0] r;
    coef[0] = 8'd2; coef[1] = 8'd3; coef[2] = 8'd1; coef[3] = 8'd1;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) b[k] = s[32*c + 8*k +: 8];
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc ^= gmul(coef[(k - row + 4) % 4], b[k]);
        r[32*c + 8*row +: 8] = acc;
      end
    end
    return r;
  endfunction

  // Abstract occupancy model: one item in flight, visible after a fixed wait.
  logic [127:0] q[$];
  bit  m_busy  = 0;
  int  m_wait  = 0;
  bit  started = 0;
  int  acc_cnt = 0;

  always @(negedge clk) begin
    if (started) begin
      if (m_busy && m_wait > 0) m_wait--;
      chk("in_ready",  128'(bus.in_ready),  128'(!m_busy));
      chk("out_valid", 128'(bus.out_valid), 128'(m_busy && m_wait == 0));
      chk("busy",      128'(bus.busy),      128'(m_busy));
      if (m_busy && m_wait == 0 && q.size() > 0) chk("out_state", bus.out_state, q[0]);
    end
    if (rst) begin
      q.delete();
      m_busy  = 0;
      m_wait  = 0;
      started = 1;
    end else if (started) begin
      if (m_busy && m_wait == 0 && bus.out_ready) begin
        void'(q.pop_front());
        m_busy = 0;
      end else if (!m_busy && bus.in_valid) begin
        q.push_back(bus.in_bypass ? bus.in_state : ref_state(bus.in_state));
        m_busy = 1;
        m_wait = bus.in_bypass ? 1 : 5;
        acc_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!bus.out_valid && n < 100) begin tick(); n++; end
  endtask

  // One full transaction from IDLE with literal expected result and latency.
  task automatic xfer(input string nm, input logic [127:0] s, input logic byp,
                      input logic [127:0] exp);
    int n;
    chk({nm, "_idle_ready"}, 128'(bus.in_ready), 128'(1));
    bus.in_valid = 1'b1; bus.in_state = s; bus.in_bypass = byp; bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    wait_out(n);
    chk({nm, "_latency"}, 128'(n + 1), byp ? 128'(1) : 128'(5));
    chk({nm, "_result"}, bus.out_state, exp);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  localparam logic [127:0] V2_IN  = {32'h4c31262d, 32'hd5d4d4d4, 32'h5c220af2, 32'h455313db};
  localparam logic [127:0] V2_OUT = {32'hf8bd7e4d, 32'hd6d7d5d5, 32'h9d58dc9f, 32'hbca14d8e};
  localparam logic [127:0] V1_IN  = {96'h0, 32'h455313db};
  localparam logic [127:0] V1_OUT = {96'h0, 32'hbca14d8e};
  localparam logic [127:0] FIXP   = {32'h01010101, 32'hc6c6c6c6, 32'hc6c6c6c6, 32'h01010101};

  initial begin
    int n;
    int base;
    logic [127:0] sa, sb;
    bus.in_valid = 1'b0; bus.in_state = '0; bus.in_bypass = 1'b0; bus.out_ready = 1'b0;

    // Pin the model against known vectors.
    chk("model_v1", ref_state(V1_IN), V1_OUT);
    chk("model_v2", ref_state(V2_IN), V2_OUT);
    chk("model_fix", ref_state(FIXP), FIXP);

    // Reset state, observed while reset is still held.
    tick();
    chk("rst_in_ready",  128'(bus.in_ready),  128'(1));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_busy",      128'(bus.busy),      128'(0));
    chk("rst_out_state", bus.out_state,       128'(0));
    tick();
    rst = 1'b0;
    tick();

    xfer("t1_col", V1_IN, 1'b0, V1_OUT);
    xfer("t2_full", V2_IN, 1'b0, V2_OUT);
    xfer("t2_fixed", FIXP, 1'b0, FIXP);
    xfer("t3_bypass", V2_IN, 1'b1, V2_IN);

    // Backpressure: hold result 10 cycles while a second input waits.
    sa = {$urandom, $urandom, $urandom, $urandom};
    sb = {$urandom, $urandom, $urandom, $urandom};
    bus.in_valid = 1'b1; bus.in_state = sa; bus.in_bypass = 1'b0;
    tick();
    bus.in_state = sb;
    wait_out(n);
    repeat (10) begin
      chk("t4_hold_valid", 128'(bus.out_valid), 128'(1));
      chk("t4_hold_state", bus.out_state, ref_state(sa));
      chk("t4_hold_ready", 128'(bus.in_ready), 128'(0));
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("t4_idle_ready", 128'(bus.in_ready), 128'(1));
    chk("t4_idle_busy",  128'(bus.busy), 128'(0));
    tick();
    bus.in_valid = 1'b0;
    chk("t4_second_busy", 128'(bus.busy), 128'(1));
    wait_out(n);
    chk("t4_second_state", bus.out_state, ref_state(sb));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Reset in the cnt=2 cycle of RUN.
    bus.in_valid = 1'b1; bus.in_state = V2_IN; bus.in_bypass = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_in_ready",  128'(bus.in_ready),  128'(1));
    chk("t5_out_valid", 128'(bus.out_valid), 128'(0));
    chk("t5_busy",      128'(bus.busy),      128'(0));
    chk("t5_buf_clear", bus.out_state,       128'(0));
    xfer("t5_after", V1_IN, 1'b0, V1_OUT);

    // Random stream with random valid/ready; the compare process checks order.
    base = acc_cnt;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (acc_cnt - base >= 8 && !m_busy) break;
      if (acc_cnt - base < 8) begin
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.in_state  = {$urandom, $urandom, $urandom, $urandom};
        bus.in_bypass = 1'($urandom_range(0, 1));
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    chk("t6_accepted", 128'(acc_cnt - base >= 8), 128'(1));
    chk("t6_drained",  128'(q.size()), 128'(0));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
